// File: rtl/stopwatch_ctrl.sv
// Run-mode controller for the MM:SS stopwatch: pause debounce, mode FSM,
// gated 1 Hz count enable, 2 Hz adjust increments and display blink phase.
//
// state  | meaning
// IDLE   | reset state, waiting for the first press
// RUN    | counting seconds on tick_1hz
// PAUSED | counting frozen, press resumes
// ADJUST | adj switch high, 2 Hz increments of the selected field
module stopwatch_ctrl #(
  parameter int DEB_SAMPLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       sample_en,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic       cnt_en,
  output logic       adj_inc,
  output logic       adj_sel,
  output logic       blink,
  output logic       running,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_PAUSED = 2'b10;
  localparam logic [1:0] S_ADJUST = 2'b11;

  localparam logic [3:0] DEB_N = 4'(DEB_SAMPLES);

  logic       p_s1;
  logic       p_s2;
  logic       deb_lvl;
  logic [3:0] deb_cnt;
  logic       deb_done;
  logic       pev;
  logic [1:0] state_nxt;

  // The level flips on the sample that completes the run; a rising flip is
  // the press event and is consumed by the FSM in that same cycle.
  always_comb begin
    deb_done = sample_en && (p_s2 != deb_lvl) && ((deb_cnt + 4'd1) == DEB_N);
    pev      = deb_done && p_s2;
  end

  always_comb begin
    state_nxt = state;
    if (adj && (state != S_ADJUST)) begin
      state_nxt = S_ADJUST;
    end else if ((state == S_ADJUST) && !adj) begin
      state_nxt = S_PAUSED;
    end else if (pev) begin
      case (state)
        S_IDLE:   state_nxt = S_RUN;
        S_RUN:    state_nxt = S_PAUSED;
        S_PAUSED: state_nxt = S_RUN;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_s1    <= 1'b0;
      p_s2    <= 1'b0;
      deb_lvl <= 1'b0;
      deb_cnt <= 4'd0;
    end else begin
      p_s1 <= pause;
      p_s2 <= p_s1;
      if (sample_en) begin
        if (p_s2 == deb_lvl) begin
          deb_cnt <= 4'd0;
        end else if (deb_done) begin
          deb_lvl <= p_s2;
          deb_cnt <= 4'd0;
        end else begin
          deb_cnt <= deb_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt_en  <= 1'b0;
      adj_inc <= 1'b0;
      adj_sel <= 1'b0;
      blink   <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == S_RUN);
      // Gating uses the pre-transition state so a tick during RUN->PAUSED
      // still counts and a tick during entry into RUN does not.
      cnt_en  <= tick_1hz && (state == S_RUN);
      adj_inc <= tick_2hz && (state == S_ADJUST);
      if (tick_2hz) begin
        adj_sel <= sel;
      end
      if ((state == S_ADJUST) && (state_nxt == S_ADJUST)) begin
        blink <= blink ^ tick_2hz;
      end else begin
        blink <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus a random
// phase, all checked each cycle against a behavioural mode model.
module tb_stopwatch_ctrl;

  localparam int DEB = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_ADJ = 3;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, tick_2hz, sample_en, pause, adj, sel;
  logic       cnt_en, adj_inc, adj_sel, blink, running;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int n_cnt = 0;
  int n_inc = 0;

  stopwatch_ctrl #(.DEB_SAMPLES(DEB)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .sample_en(sample_en), .pause(pause), .adj(adj), .sel(sel),
    .cnt_en(cnt_en), .adj_inc(adj_inc), .adj_sel(adj_sel), .blink(blink),
    .running(running), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: pause seen two edges late, level accepted after DEB
  // consecutive disagreeing samples, blink = parity of ticks seen in ADJUST.
  int   m_mode = M_IDLE;
  bit   m_p1, m_p2, m_lvl;
  bit   deb_q[$];
  int   m_nticks;
  logic e_cnt, e_inc, e_sel, e_blink, e_run;

  always @(posedge clk) begin
    bit s, pev;
    int nm;
    if (rst) begin
      m_mode = M_IDLE; m_p1 = 0; m_p2 = 0; m_lvl = 0; deb_q.delete();
      m_nticks = 0;
      e_cnt = 0; e_inc = 0; e_sel = 0; e_blink = 0; e_run = 0;
    end else begin
      s = m_p2; m_p2 = m_p1; m_p1 = pause;
      pev = 0;
      if (sample_en) begin
        if (s == m_lvl) deb_q.delete();
        else deb_q.push_back(s);
        if (deb_q.size() == DEB) begin
          m_lvl = s; pev = s; deb_q.delete();
        end
      end
      nm = m_mode;
      if (adj && m_mode != M_ADJ) nm = M_ADJ;
      else if (m_mode == M_ADJ && !adj) nm = M_PAUSED;
      else if (pev && m_mode == M_IDLE) nm = M_RUN;
      else if (pev && m_mode == M_RUN) nm = M_PAUSED;
      else if (pev && m_mode == M_PAUSED) nm = M_RUN;
      e_cnt = tick_1hz && (m_mode == M_RUN);
      e_inc = tick_2hz && (m_mode == M_ADJ);
      if (tick_2hz) e_sel = sel;
      if (m_mode == M_ADJ && nm == M_ADJ) begin
        if (tick_2hz) m_nticks++;
        e_blink = (m_nticks % 2) == 1;
      end else begin
        m_nticks = 0;
        e_blink = 0;
      end
      e_run = (nm == M_RUN);
      m_mode = nm;
    end
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    chk("state", state, 2'(m_mode));
    chk("cnt_en", {1'b0, cnt_en}, {1'b0, e_cnt});
    chk("adj_inc", {1'b0, adj_inc}, {1'b0, e_inc});
    chk("adj_sel", {1'b0, adj_sel}, {1'b0, e_sel});
    chk("blink", {1'b0, blink}, {1'b0, e_blink});
    chk("running", {1'b0, running}, {1'b0, e_run});
    chk("exclusive", {1'b0, cnt_en & adj_inc}, 2'b00);
    if (cnt_en) n_cnt++;
    if (adj_inc) n_inc++;
    sample_en = 0; tick_1hz = 0; tick_2hz = 0;
  endtask

  task automatic samp(input int n);
    repeat (n) begin
      sample_en = 1; clk1(); clk1();
    end
  endtask

  task automatic press();
    pause = 1; clk1(); clk1(); samp(DEB);
  endtask

  task automatic release_btn();
    pause = 0; clk1(); clk1(); samp(DEB);
  endtask

  initial begin
    rst = 1; tick_1hz = 0; tick_2hz = 0; sample_en = 0; pause = 1; adj = 1; sel = 0;
    // reset with pause and adj asserted
    repeat (3) begin
      sample_en = 1; tick_1hz = 1; tick_2hz = 1;
      clk1();
      chk("rst_state", state, 2'b00);
      chk("rst_outs", {1'b0, cnt_en | adj_inc | blink | running}, 2'b00);
    end
    rst = 0; clk1();
    chk("post_rst_adj", state, 2'b11);
    rst = 1; pause = 0; adj = 0; clk1(); clk1();
    rst = 0; clk1();

    // short press rejected, full press accepted, hold gives no more events
    pause = 1; clk1(); clk1(); samp(2);
    pause = 0; clk1(); clk1(); samp(3);
    chk("short_press", state, 2'b00);
    press();
    chk("press_run", state, 2'b01);
    pause = 1; samp(20);
    chk("hold_run", state, 2'b01);
    release_btn();
    chk("release_run", state, 2'b01);

    // counting in RUN
    n_cnt = 0;
    repeat (5) begin
      tick_1hz = 1; clk1();
      chk("cnt_pulse", {1'b0, cnt_en}, 2'b01);
      clk1();
      chk("cnt_width", {1'b0, cnt_en}, 2'b00);
      repeat ($urandom_range(0, 4)) clk1();
    end
    chk("cnt_total5", 2'(n_cnt), 2'(5 % 4));
    total++;
    assert (n_cnt == 5) else begin
      bad++; $error("FAIL cnt_total observed=%0d expected=5", n_cnt);
    end
    press();
    chk("pause_state", state, 2'b10);
    n_cnt = 0;
    repeat (3) begin
      tick_1hz = 1; clk1(); repeat ($urandom_range(1, 3)) clk1();
    end
    total++;
    assert (n_cnt == 0) else begin
      bad++; $error("FAIL paused_cnt observed=%0d expected=0", n_cnt);
    end
    release_btn();
    press();
    chk("resume_run", state, 2'b01);
    release_btn();

    // press coincident with tick_1hz: tick still counted
    pause = 1; clk1(); clk1(); samp(DEB - 1);
    sample_en = 1; tick_1hz = 1; clk1();
    chk("sim_cnt", {1'b0, cnt_en}, 2'b01);
    chk("sim_paused", state, 2'b10);
    release_btn();

    // press coincident with adj rise from PAUSED: press dropped
    pause = 1; clk1(); clk1(); samp(DEB - 1);
    sample_en = 1; adj = 1; clk1();
    chk("sim_adj", state, 2'b11);
    adj = 0; clk1();
    chk("sim_adj_exit", state, 2'b10);
    samp(3);
    chk("pev_dropped", state, 2'b10);
    release_btn();

    // adjust mode, minutes field
    adj = 1; sel = 1; clk1();
    chk("adj_enter", state, 2'b11);
    n_inc = 0;
    for (int i = 0; i < 4; i++) begin
      tick_2hz = 1; clk1();
      chk("adj_inc", {1'b0, adj_inc}, 2'b01);
      chk("adj_sel", {1'b0, adj_sel}, 2'b01);
      chk("blink_seq", {1'b0, blink}, (i % 2 == 0) ? 2'b01 : 2'b00);
      repeat ($urandom_range(1, 3)) begin
        tick_1hz = 1'($urandom_range(0, 1)); clk1();
        chk("adj_no_cnt", {1'b0, cnt_en}, 2'b00);
      end
    end
    total++;
    assert (n_inc == 4) else begin
      bad++; $error("FAIL adj_inc_total observed=%0d expected=4", n_inc);
    end
    adj = 0; clk1();
    chk("adj_exit", state, 2'b10);
    chk("adj_exit_blink", {1'b0, blink}, 2'b00);

    // reset mid-adjust while blanked
    adj = 1; sel = 0; clk1();
    tick_2hz = 1; clk1();
    chk("pre_rst_blink", {1'b0, blink}, 2'b01);
    adj = 0; rst = 1; tick_2hz = 1; clk1();
    chk("mid_rst_state", state, 2'b00);
    chk("mid_rst_blink", {1'b0, blink}, 2'b00);
    chk("mid_rst_inc", {1'b0, adj_inc}, 2'b00);
    rst = 0; clk1();

    // random phase against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      if ($urandom_range(0, 199) == 0) adj = ~adj;
      if ($urandom_range(0, 15) == 0) sel = ~sel;
      sample_en = ($urandom_range(0, 3) == 0);
      tick_1hz  = ($urandom_range(0, 9) == 0);
      tick_2hz  = ($urandom_range(0, 7) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      clk1();
      rst = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run-mode controller for the 4-digit MM:SS stopwatch. It debounces the pause button and sequences the stopwatch through idle, running, paused and adjust modes. It gates the 1 Hz count enable to the digit counters and issues 2 Hz adjust-increment pulses. It also drives the blink control for the display multiplexer. It sits between the clock divider's enable outputs and the counter/display blocks.

Parameters:
DEB_SAMPLES, 3, consecutive equal samples of pause at sample_en needed to accept a level change (1..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tick_1hz  input  1  one-clk-wide pulse, 1 Hz, from clock divider
tick_2hz  input  1  one-clk-wide pulse, 2 Hz, from clock divider
sample_en  input  1  one-clk-wide pulse, 400 Hz, debounce sampling strobe
pause  input  1  raw pause button, active high, asynchronous to clk
adj  input  1  adjust-mode switch level (already synchronised)
sel  input  1  adjust field select: 0 = seconds, 1 = minutes
cnt_en  output  1  one-clk pulse: advance the stopwatch by one second
adj_inc  output  1  one-clk pulse: increment the selected field
adj_sel  output  1  registered copy of sel, valid with adj_inc
blink  output  1  display blink phase for the selected field: 1 = blank
running  output  1  high in RUN
state  output  2  00 IDLE, 01 RUN, 10 PAUSED, 11 ADJUST

Behaviour:
- All outputs and state are registered. On rst=1 at a clk edge: state=IDLE, all outputs 0, sync flops 0, debounce count 0, debounced level 0.
- pause passes through a 2-flop synchroniser. Debounce:
  - On each sample_en, compare the synchronised value with the debounced level.
  - If they differ, increment the count; otherwise clear it.
  - When the count reaches DEB_SAMPLES, update the level and clear the count.
- A press event (pev) is a 0->1 change of the debounced level. It is one clk wide and is used in the same cycle it is generated.
- FSM transitions, evaluated each clk, priority top-down:
  - adj=1 and state!=ADJUST -> ADJUST; any pev in this cycle is discarded.
  - ADJUST and adj=0 -> PAUSED.
  - IDLE and pev -> RUN.
  - RUN and pev -> PAUSED.
  - PAUSED and pev -> RUN.
  - Otherwise hold.
- cnt_en = 1 in the cycle after tick_1hz only if state==RUN in the tick_1hz cycle. A tick coincident with a RUN->PAUSED pev is still counted. A tick coincident with an entry into RUN is not counted.
- adj_inc = 1 in the cycle after tick_2hz only if state==ADJUST in the tick_2hz cycle. adj_sel is sampled from sel in that same tick_2hz cycle.
- blink:
  - Toggles on each tick_2hz while in ADJUST.
  - Forced to 0 on entering ADJUST and in any other state.
  - Blink period is 1 s.
- running = (state==RUN), registered with the state.
- cnt_en and adj_inc are never both 1.
- At most one state transition per clk.
- Reset mid-operation: takes effect at the next edge regardless of mode. Any pending debounce count is lost.
- A held pause button yields exactly one pev. Release produces no event.
- Expected RTL size: about 150-220 lines.

Test Plan:
- Reset: assert rst for 3 clk with pause=1, adj=1 -> state=00, cnt_en=adj_inc=blink=running=0 during reset. After release, state becomes 11 within one clk (adj still 1).
- Debounce (DEB_SAMPLES=3): pause high for 2 sample_en, then low -> no pev, state stays IDLE. Pause high for 3 samples -> exactly one pev, IDLE->RUN. Hold high for 20 more samples -> no further transition.
- Counting: in RUN apply 5 tick_1hz -> exactly 5 cnt_en pulses, each 1 clk long, 1 clk after its tick. Then press pause -> PAUSED; 3 more tick_1hz -> 0 cnt_en. Press again -> RUN.
- Simultaneous: pev (RUN->PAUSED) in the same clk as tick_1hz -> one cnt_en, then state=10. Pev and adj rise in the same clk from PAUSED -> state=11, and after adj falls state=10 (pev dropped).
- Adjust: adj=1, sel=1, apply 4 tick_2hz -> 4 adj_inc pulses with adj_sel=1, blink sequence 1,0,1,0, cnt_en=0 throughout. Drop adj -> state=10, blink=0.
- Reset mid-adjust: assert rst while blink=1 in ADJUST with adj=0 afterwards -> next clk state=00, blink=0, no adj_inc.
